mem_arbiter: RTL and testbench

- Single-port RAM arbiter and sequencer between the instruction-fetch port and the data-memory port of the pipelined datapath.
- Accepts read requests from the instruction side and read/write requests from the data side.
- Grants exactly one requester at a time, drives the shared RAM, and returns load data with per-port wait handshakes.
- Data port has priority; a starvation counter guarantees instruction fetch progress. Sits between the caches and the RAM model.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the instruction-fetch and data-memory ports.
//
// The data port has priority. A saturating starvation counter forces an instruction grant once
// STARVE_MAX data transactions have completed while an instruction fetch was waiting. Each grant
// latches its address, store data and op, then holds the RAM request until the RAM reports
// ACCESS. The owner's wait drops combinationally in that cycle.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        instruction read request and address
//   iwait, iload       instruction stall (low for the completion cycle) and read data
//   dREN, dWEN         data read / write requests (write wins when both are high)
//   daddr, dstore      data address and write value
//   dwait, dload       data stall (low for the completion cycle) and read data
//   ramREN, ramWEN     RAM read / write enables
//   ramaddr, ramstore  RAM address and write data
//   ramload, ramstate  RAM read data and status (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
//   bus_err            one-cycle pulse for each ERROR cycle during a grant
//   grant_d            high while the data port owns the RAM
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              bus_err,
    output logic              grant_d
);

    localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StDgrant,
        StIgrant
    } state_e;

    state_e              state_q, state_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   store_q, store_d;
    logic                wr_q, wr_d;
    logic [WORD_W-1:0]   iload_q, iload_d;
    logic [WORD_W-1:0]   dload_q, dload_d;

    logic d_req;
    logic starve_full;
    logic access;
    logic d_done;
    logic i_done;
    logic granted;

    always_comb begin
        d_req       = dREN | dWEN;
        starve_full = (starve_q == StarveMaxC);
        access      = (ramstate == RamAccess);
        granted     = (state_q != StIdle);
        // Dropping the request while granted is an abort, even if the RAM reports ACCESS.
        d_done      = (state_q == StDgrant) && d_req && access;
        i_done      = (state_q == StIgrant) && iREN && access;
    end

    // Next-state, latch and counter logic
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        iload_d  = iload_q;
        dload_d  = dload_q;

        unique case (state_q)
            StIdle: begin
                if (!iREN) begin
                    starve_d = '0;
                end
                if (d_req && !(iREN && starve_full)) begin
                    state_d = StDgrant;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN) begin
                    state_d = StIgrant;
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                end
            end
            StDgrant: begin
                if (!d_req) begin
                    state_d = StIdle;
                end else if (access) begin
                    state_d = StIdle;
                    if (!wr_q) begin
                        dload_d = ramload;
                    end
                    if (iREN && !starve_full) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end
            end
            StIgrant: begin
                if (!iREN) begin
                    state_d = StIdle;
                end else if (access) begin
                    state_d  = StIdle;
                    iload_d  = ramload;
                    starve_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            starve_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    // Outputs: RAM side follows the latched op; port side completes combinationally on ACCESS.
    always_comb begin
        ramREN   = granted && !wr_q;
        ramWEN   = granted && wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        grant_d  = (state_q == StDgrant);
        bus_err  = granted && (ramstate == RamError);
        iwait    = !i_done;
        dwait    = !d_done;
        iload    = i_done ? ramload : iload_q;
        dload    = (d_done && !wr_q) ? ramload : dload_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned W = 32;
    localparam logic [1:0] RsFree   = 2'd0;
    localparam logic [1:0] RsBusy   = 2'd1;
    localparam logic [1:0] RsAccess = 2'd2;
    localparam logic [1:0] RsError  = 2'd3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore;
    logic         iwait, dwait;
    logic [W-1:0] iload, dload;
    logic         ramREN, ramWEN;
    logic [W-1:0] ramaddr, ramstore, ramload;
    logic [1:0]   ramstate;
    logic         bus_err, grant_d;
    logic [1:0]   rs;

    logic [1:0] lat_seq [4] = '{RsBusy, RsBusy, RsError, RsAccess};

    typedef struct packed {
        logic         is_d;
        logic         is_wr;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter #(
        .STARVE_MAX(4),
        .WORD_W    (W)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .bus_err (bus_err),
        .grant_d (grant_d)
    );

    always #5 CLK = ~CLK;

    // RAM contents model: fixed word at 0x40, address-derived pattern elsewhere.
    function automatic logic [W-1:0] ram_word(input logic [W-1:0] a);
        if (a == 32'h40) return 32'h3C01ABCD;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign ramload  = ram_word(ramaddr);
    assign ramstate = rs;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic is_wr, input logic [W-1:0] data);
        exp_t e;
        e.is_d  = is_d;
        e.is_wr = is_wr;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at the negedge of the completion cycle, or flags a timeout.
    task automatic await_done(input bit want_d, input int max_cycles, output int cycles);
        cycles = 0;
        forever begin
            @(negedge CLK);
            if (want_d ? !dwait : !iwait) return;
            if (cycles >= max_cycles) begin
                check_eq("await_timeout", 32'(want_d ? dwait : iwait), 32'd0);
                return;
            end
            cycles++;
            tick();
        end
    endtask

    task automatic await_any(input int max_cycles, output bit got_d);
        got_d = 1'b0;
        for (int c = 0; c <= max_cycles; c++) begin
            @(negedge CLK);
            if (!dwait || !iwait) begin
                got_d = !dwait;
                return;
            end
            tick();
        end
        check_eq("await_any_timeout", 32'(iwait & dwait), 32'd0);
    endtask

    // Scoreboard: every wait-low cycle must match the oldest expected completion.
    always @(negedge CLK) begin : sb_monitor
        exp_t e;
        if (nRST && (!iwait || !dwait)) begin
            check_eq("single_owner", 32'(iwait | dwait), 32'd1);
            check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_port", 32'(!dwait), 32'(e.is_d));
                if (!e.is_wr) check_eq("sb_load", e.is_d ? dload : iload, e.data);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int cyc;
        bit got_d;
        int n_d;
        bit done_i;

        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        rs = RsFree;

        // Reset state
        repeat (2) @(negedge CLK);
        check_eq("rst_iwait", 32'(iwait), 32'd1);
        check_eq("rst_dwait", 32'(dwait), 32'd1);
        check_eq("rst_ramREN", 32'(ramREN), 32'd0);
        check_eq("rst_ramWEN", 32'(ramWEN), 32'd0);
        check_eq("rst_ramaddr", ramaddr, 32'd0);
        check_eq("rst_ramstore", ramstore, 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        check_eq("rst_grant_d", 32'(grant_d), 32'd0);
        check_eq("rst_iload", iload, 32'd0);
        check_eq("rst_dload", dload, 32'd0);
        nRST = 1'b1;
        tick();

        // Instruction only
        iREN = 1'b1; iaddr = 32'h40; rs = RsAccess;
        push_exp(1'b0, 1'b0, ram_word(32'h40));
        @(negedge CLK);
        check_eq("t1_c0_ramREN", 32'(ramREN), 32'd0);
        check_eq("t1_c0_iwait", 32'(iwait), 32'd1);
        tick();
        @(negedge CLK);
        check_eq("t1_c1_ramREN", 32'(ramREN), 32'd1);
        check_eq("t1_c1_ramaddr", ramaddr, 32'h40);
        check_eq("t1_c1_iwait", 32'(iwait), 32'd0);
        check_eq("t1_c1_iload", iload, 32'h3C01ABCD);
        check_eq("t1_c1_grant_d", 32'(grant_d), 32'd0);
        tick();
        iREN = 1'b0;
        @(negedge CLK);
        check_eq("t1_c2_ramREN", 32'(ramREN), 32'd0);
        check_eq("t1_c2_iwait", 32'(iwait), 32'd1);
        check_eq("t1_c2_iload_hold", iload, 32'h3C01ABCD);
        tick();

        // Simultaneous requests: data write first, then instruction
        iREN = 1'b1; iaddr = 32'h80;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        push_exp(1'b1, 1'b1, 32'h0);
        push_exp(1'b0, 1'b0, ram_word(32'h80));
        @(negedge CLK);
        check_eq("t2_c0_grant_d", 32'(grant_d), 32'd0);
        tick();
        @(negedge CLK);
        check_eq("t2_c1_grant_d", 32'(grant_d), 32'd1);
        check_eq("t2_c1_ramWEN", 32'(ramWEN), 32'd1);
        check_eq("t2_c1_ramREN", 32'(ramREN), 32'd0);
        check_eq("t2_c1_ramaddr", ramaddr, 32'h100);
        check_eq("t2_c1_ramstore", ramstore, 32'hDEADBEEF);
        check_eq("t2_c1_dwait", 32'(dwait), 32'd0);
        check_eq("t2_c1_iwait", 32'(iwait), 32'd1);
        check_eq("t2_c1_dload_hold", dload, 32'd0);
        tick();
        dWEN = 1'b0;
        @(negedge CLK);
        check_eq("t2_c2_idle_grant_d", 32'(grant_d), 32'd0);
        check_eq("t2_c2_idle_ramWEN", 32'(ramWEN), 32'd0);
        check_eq("t2_c2_idle_ramREN", 32'(ramREN), 32'd0);
        check_eq("t2_c2_iwait", 32'(iwait), 32'd1);
        tick();
        @(negedge CLK);
        check_eq("t2_c3_ramREN", 32'(ramREN), 32'd1);
        check_eq("t2_c3_ramaddr", ramaddr, 32'h80);
        check_eq("t2_c3_iwait", 32'(iwait), 32'd0);
        tick();
        iREN = 1'b0;
        tick();

        // Starvation: four data completions, then the instruction is forced
        iREN = 1'b1; iaddr = 32'hC0;
        dREN = 1'b1; daddr = 32'h300;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, ram_word(32'h300 + 32'(4 * k)));
        push_exp(1'b0, 1'b0, ram_word(32'hC0));
        n_d = 0;
        done_i = 1'b0;
        for (int k = 0; k < 8 && !done_i; k++) begin
            await_any(6, got_d);
            if (got_d) begin
                n_d++;
            end else begin
                done_i = 1'b1;
                check_eq("starve_d_count", n_d, 4);
                check_eq("starve_at_igrant", 32'(dut.starve_q), 32'd4);
            end
            tick();
            if (got_d) daddr = 32'h300 + 32'(4 * n_d);
        end
        iREN = 1'b0;
        dREN = 1'b0;
        check_eq("starve_igrant_seen", 32'(done_i), 32'd1);
        @(negedge CLK);
        check_eq("starve_cleared", 32'(dut.starve_q), 32'd0);
        tick();

        // RAM latency and error retry on a data read
        dREN = 1'b1; daddr = 32'h200; rs = RsBusy;
        push_exp(1'b1, 1'b0, ram_word(32'h200));
        @(negedge CLK);
        check_eq("t4_c0_ramREN", 32'(ramREN), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            rs = lat_seq[k-1];
            @(negedge CLK);
            check_eq($sformatf("t4_c%0d_ramREN", k), 32'(ramREN), 32'd1);
            check_eq($sformatf("t4_c%0d_bus_err", k), 32'(bus_err), 32'(k == 3));
            check_eq($sformatf("t4_c%0d_dwait", k), 32'(dwait), 32'(k != 4));
            if (k == 4) check_eq("t4_c4_dload", dload, ram_word(32'h200));
        end
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        check_eq("t4_c5_ramREN", 32'(ramREN), 32'd0);
        check_eq("t4_c5_dload_hold", dload, ram_word(32'h200));
        tick();

        // Abort: data request dropped before ACCESS, pending instruction proceeds
        iREN = 1'b1; iaddr = 32'h500;
        dREN = 1'b1; daddr = 32'h600; rs = RsBusy;
        push_exp(1'b0, 1'b0, ram_word(32'h500));
        tick();
        @(negedge CLK);
        check_eq("t5_c1_grant_d", 32'(grant_d), 32'd1);
        check_eq("t5_c1_ramaddr", ramaddr, 32'h600);
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        check_eq("t5_c2_dwait", 32'(dwait), 32'd1);
        check_eq("t5_c2_ramREN", 32'(ramREN), 32'd1);
        tick();
        rs = RsAccess;
        @(negedge CLK);
        check_eq("t5_c3_ramREN", 32'(ramREN), 32'd0);
        check_eq("t5_c3_grant_d", 32'(grant_d), 32'd0);
        tick();
        @(negedge CLK);
        check_eq("t5_c4_iwait", 32'(iwait), 32'd0);
        check_eq("t5_c4_ramaddr", ramaddr, 32'h500);
        tick();
        iREN = 1'b0;
        tick();

        // Asynchronous reset in the middle of an instruction grant
        iREN = 1'b1; iaddr = 32'h700; rs = RsBusy;
        tick();
        @(negedge CLK);
        check_eq("t6_ramREN_pre", 32'(ramREN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("t6_rst_ramREN", 32'(ramREN), 32'd0);
        check_eq("t6_rst_iwait", 32'(iwait), 32'd1);
        check_eq("t6_rst_grant_d", 32'(grant_d), 32'd0);
        check_eq("t6_rst_iload", iload, 32'd0);
        iREN = 1'b0;
        tick();
        tick();
        #2;
        nRST = 1'b1;
        tick();
        iREN = 1'b1; iaddr = 32'h44; rs = RsAccess;
        push_exp(1'b0, 1'b0, ram_word(32'h44));
        await_done(1'b0, 5, cyc);
        check_eq("t6_recover_latency", cyc, 1);
        tick();
        iREN = 1'b0;
        repeat (2) tick();

        check_eq("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
